// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slice.
// Holds the FSM state type, command encodings and the frame/read/counter widths.
package spi_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned READ_W  = 8;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_CMD   = 3'd2,
    S_SHIFT = 3'd3,
    S_TURN  = 3'd4,
    S_READ  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_master_if.sv
// Request/response and serial-line bundle between a frame requester and spi_master.
// Signals: start, tx_frame[9:0] (requester -> master); busy, done, rd_data[7:0],
// rd_valid, err_busy (master -> requester); SS_n, MOSI (master -> slave); MISO (slave -> master).
interface spi_master_if;
  import spi_pkg::*;

  logic               start;
  logic [FRAME_W-1:0] tx_frame;
  logic               busy;
  logic               done;
  logic [READ_W-1:0]  rd_data;
  logic               rd_valid;
  logic               err_busy;
  logic               SS_n;
  logic               MOSI;
  logic               MISO;

  modport master (
    input  start, tx_frame, MISO,
    output busy, done, rd_data, rd_valid, err_busy, SS_n, MOSI
  );

  modport slave (
    output start, tx_frame, MISO,
    input  busy, done, rd_data, rd_valid, err_busy, SS_n, MOSI
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Parameterized shift register: parallel load, shift toward the MSB with serial input at the LSB.
// Ports: clk, rst (async active-high), load, shift, din[W-1:0], sin, q[W-1:0] (MSB is the serial out).
module spi_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  input  logic         sin,
  output logic [W-1:0] q
);

  // Load has priority over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_master.sv
// Clock-synchronous SPI frame master: select cycle, command bit, 10-bit payload,
// optional turnaround plus 8-bit read, then an inter-frame gap.
// Ports: clk, rst (async active-high), bus (spi_master_if.master).
// Parameters: TURNAROUND (1..15), GAP (1..15).
// Optional: SPI_MASTER_BUSY_ERR_EN enables err_busy detection; otherwise err_busy is tied 0.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP        = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST  = CNT_W'(READ_W - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_W);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cmd_q;
  logic               tx_load, tx_shift, rx_shift, rd_load;
  logic [FRAME_W-1:0] tx_q;
  logic [READ_W-1:0]  rx_q;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_valid_q, rd_valid_d;
  logic [READ_W-1:0]  rd_data_q;
  logic               unused_bits;

  // Payload copy taken at accept so tx_frame may change mid-frame.
  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (tx_load),
    .shift (tx_shift),
    .din   (bus.tx_frame),
    .sin   (1'b0),
    .q     (tx_q)
  );

  spi_shift_reg #(.W(READ_W)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .shift (rx_shift),
    .din   ('0),
    .sin   (bus.MISO),
    .q     (rx_q)
  );

  // Only the TX MSB and the low RX bits feed the datapath directly.
  assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[READ_W-1]};

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= CMD_WR_ADDR;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      if (tx_load) cmd_q <= bus.tx_frame[FRAME_W-1:FRAME_W-2];
      // 8th sample goes straight into rd_data alongside the first seven.
      if (rd_load) rd_data_q <= {rx_q[READ_W-2:0], bus.MISO};
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    rd_load  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = S_SEL;
          tx_load = 1'b1;
        end
      end
      S_SEL: begin
        state_d = S_CMD;
        cnt_d   = '0;
      end
      // TX advances from CMD onward; MOSI always takes the pre-shift MSB.
      S_CMD: begin
        state_d  = S_SHIFT;
        cnt_d    = '0;
        tx_shift = 1'b1;
      end
      S_SHIFT: begin
        tx_shift = 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = (cmd_q == CMD_RD_DATA) ? S_TURN : S_GAP;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      // Eight sample cycles, then one completion cycle with SS_n still low.
      S_READ: begin
        rx_shift = (cnt_q < READ_LAST);
        rd_load  = (cnt_q == SAMP_LAST);
        if (cnt_q == READ_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    ss_n_d     = !(state_d inside {S_SEL, S_CMD, S_SHIFT, S_TURN, S_READ});
    mosi_d     = (state_d == S_CMD || state_d == S_SHIFT) ? tx_q[FRAME_W-1] : 1'b0;
    busy_d     = (state_d != S_IDLE);
    rd_valid_d = (state_d == S_READ) && (cnt_d == READ_LAST);
    done_d     = rd_valid_d ||
                 ((state_d == S_SHIFT) && (cnt_d == SHIFT_LAST) && (cmd_q != CMD_RD_DATA));
  end

`ifdef SPI_MASTER_BUSY_ERR_EN
  logic err_busy_q;

  // Flags a start request that arrives while a frame is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_busy_q <= 1'b0;
    else     err_busy_q <= bus.start & busy_q;
  end

  assign bus.err_busy = err_busy_q;
`else
  assign bus.err_busy = 1'b0;
`endif

  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: TURNAROUND, default 2, number of clk cycles between the last payload bit and the first MISO sample in a read-data frame (range 1..15).
REQ-002 Parameter: GAP, default 2, minimum number of clk cycles SS_n is held high between frames (range 1..15).
REQ-003 Port: clk  input  1  system clock; all logic is on posedge clk.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request to send one frame; sampled only in IDLE.
REQ-006 Port: tx_frame  input  10  payload; [9:8] are the command (00 write-addr, 01 write-data, 10 read-addr, 11 read-data), [7:0] are the address or data.
REQ-007 Port: busy  output  1  high from the cycle after start is accepted until the end of GAP.
REQ-008 Port: done  output  1  one-cycle pulse on the last cycle SS_n is low.
REQ-009 Port: rd_data  output  8  byte captured in a read-data frame.
REQ-010 Port: rd_valid  output  1  one-cycle pulse, coincident with done, for read-data frames only.
REQ-011 Port: err_busy  output  1  one-cycle pulse when start is seen while busy (see Configuration).
REQ-012 Port: SS_n  output  1  active-low slave select.
REQ-013 Port: MOSI  output  1  serial data to the slave, MSB first.
REQ-014 Port: MISO  input  1  serial data from the slave, MSB first.

Function
REQ-015 The FSM SHALL have states IDLE, SEL, CMD, SHIFT, TURN, READ and GAP, with sequential encoding.
- IDLE: SS_n=1.
- start=1 latches tx_frame and moves to SEL.
REQ-016 SEL SHALL last 1 cycle with SS_n=0 and MOSI=0, giving the slave its select-detect cycle.
REQ-017 CMD SHALL last 1 cycle with MOSI=tx_frame[9], the write(0)/read(1) selector.
REQ-018 SHIFT SHALL last 10 cycles, driving MOSI=tx_frame[9] down to tx_frame[0], one bit per cycle.
REQ-019 After SHIFT:
- command 11 SHALL go to TURN.
- all other commands SHALL go to GAP.
- done SHALL pulse on the last SHIFT cycle for commands other than 11.
REQ-020 TURN SHALL last TURNAROUND cycles, with SS_n=0 and MOSI=0.
REQ-021 READ SHALL last 8 cycles, sampling MISO into rd_data[7] down to rd_data[0].
- rd_data SHALL update and rd_valid/done SHALL pulse on the cycle after the 8th sample.
- SS_n SHALL stay 0 through that cycle.
REQ-022 GAP SHALL hold SS_n=1 and MOSI=0 for GAP cycles, then return to IDLE.
- start is ignored throughout GAP.
REQ-023 Frame length, start accepted to SS_n rising:
- 12 cycles for commands 00/01/10.
- 12+TURNAROUND+9 cycles for command 11.
REQ-024 rd_data SHALL hold its last value until the next read-data frame completes.
REQ-025 tx_frame changes while busy SHALL NOT affect the frame in flight.
REQ-026 A 4-bit bit counter SHALL reload on each state entry; no counter SHALL wrap within a state.

Reset
REQ-027 While rst is high, and immediately on its assertion, the block SHALL force:
- state IDLE.
- SS_n=1, MOSI=0.
- busy=0, done=0, rd_valid=0, err_busy=0.
- rd_data=8'h00.
REQ-028 A reset mid-frame SHALL abort the frame with no done or rd_valid pulse.
- The first start after reset release SHALL produce a complete, correct frame.

Configuration
REQ-029 With SPI_MASTER_BUSY_ERR_EN defined:
- err_busy SHALL pulse for 1 cycle each cycle start=1 while busy=1.
- The in-flight frame SHALL be unaffected.
REQ-030 Without SPI_MASTER_BUSY_ERR_EN, err_busy SHALL be tied to 0 and its detection logic SHALL be omitted.

Structure
REQ-031 A shared package spi_pkg SHALL hold:
- the state typedef.
- the command encodings CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA.
- the frame width 10 and the read width 8.
REQ-032 One sub-module, spi_shift_reg, SHALL be used: a parameterized-width shift register with load, shift-out (MSB) and shift-in (LSB).
- It SHALL be instantiated once for TX (width 10) and once for RX (width 8).

Verification
REQ-033 Write-address: start with tx_frame=10'h0A5 -> MOSI after the select cycle is 0,0,0,1,0,1,0,0,1,0,1; done pulses in cycle 12; SS_n is high in cycle 13.
REQ-034 Read-data: tx_frame=10'h3FF, TURNAROUND=2, slave model returns 8'hC3 -> rd_data=8'hC3 with rd_valid and done coincident in cycle 23; SS_n rises in cycle 24.
REQ-035 Back-to-back: start held high -> SS_n stays high for exactly GAP cycles between frames, and two complete frames are observed.
REQ-036 Reset mid-frame: rst asserted in SHIFT bit 4 -> SS_n=1 immediately; no done pulse; the next frame is correct.
REQ-037 Busy error, run with and without SPI_MASTER_BUSY_ERR_EN: start pulsed in READ -> err_busy pulses once (0 without the macro); rd_data is unaffected.
REQ-038 Integration: spi_master connected to the existing SPI slave with frames 10'h000, 10'h1AB, 10'h200 and 10'h300 -> the slave shows rx_valid with rx_data equal to each frame.
